// File: rtl/i2c_reg_slave.sv
// I2C target bridging SCL/SDA (oversampled on clk) to a one-cycle strobe register bus with pointer auto-increment.
// Pins reach the FSM ~5 clks after the pad; SCL is never stretched; rd_data is captured 1 clk after rd_en.
module i2c_reg_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         FILT     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic       wr_en,
    output logic [7:0] wr_data,
    output logic       rd_en,
    input  logic [7:0] rd_data,
    output logic       busy
);
    localparam int CW = $clog2(FILT + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    // Bit 1 carries SCL, bit 0 carries SDA through sync, filter and edge stages.
    logic [1:0]    sync0, sync1, filt, filt_d;
    logic [CW-1:0] cnt [2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0  <= 2'b11;
            sync1  <= 2'b11;
            filt   <= 2'b11;
            filt_d <= 2'b11;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync0  <= {scl_in, sda_in};
            sync1  <= sync0;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync1[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(FILT - 1)) begin
                    filt[i] <= sync1[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_c, stop_c, sda;
    assign sda      = filt[0];
    assign scl_rise =  filt[1] & ~filt_d[1];
    assign scl_fall = ~filt[1] &  filt_d[1];
    assign start_c  = filt[1] & filt_d[1] &  filt_d[0] & ~filt[0];
    assign stop_c   = filt[1] & filt_d[1] & ~filt_d[0] &  filt[0];

    state_t     state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shreg, shreg_nxt, reg_addr_nxt, wr_data_nxt;
    logic       got8, got8_nxt, rw, rw_nxt, ack_bit, ack_bit_nxt, load_pend, load_pend_nxt;
    logic       sda_oe_nxt, busy_nxt, wr_en_nxt, rd_en_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'd0;
            got8      <= 1'b0;
            rw        <= 1'b0;
            ack_bit   <= 1'b1;
            load_pend <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_en     <= 1'b0;
            wr_data   <= 8'd0;
            rd_en     <= 1'b0;
            reg_addr  <= 8'd0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            got8      <= got8_nxt;
            rw        <= rw_nxt;
            ack_bit   <= ack_bit_nxt;
            load_pend <= load_pend_nxt;
            sda_oe    <= sda_oe_nxt;
            busy      <= busy_nxt;
            wr_en     <= wr_en_nxt;
            wr_data   <= wr_data_nxt;
            rd_en     <= rd_en_nxt;
            reg_addr  <= reg_addr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        got8_nxt      = got8;
        rw_nxt        = rw;
        ack_bit_nxt   = ack_bit;
        load_pend_nxt = rd_en;
        sda_oe_nxt    = sda_oe;
        busy_nxt      = busy;
        wr_en_nxt     = 1'b0;
        wr_data_nxt   = wr_data;
        rd_en_nxt     = 1'b0;
        reg_addr_nxt  = wr_en ? reg_addr + 8'd1 : reg_addr;

        // A byte fetched after a master ACK arrives mid-low-phase, so its MSB is driven on arrival.
        if (load_pend) begin
            if (state == RDATA) begin
                shreg_nxt  = {rd_data[6:0], 1'b0};
                sda_oe_nxt = ~rd_data[7];
            end else if (state == ADDR_ACK) begin
                shreg_nxt = rd_data;
            end
        end

        if (start_c) begin
            state_nxt   = ADDR;
            busy_nxt    = 1'b1;
            bit_cnt_nxt = 3'd0;
            got8_nxt    = 1'b0;
            sda_oe_nxt  = 1'b0;
        end else if (stop_c) begin
            state_nxt   = IDLE;
            busy_nxt    = 1'b0;
            bit_cnt_nxt = 3'd0;
            got8_nxt    = 1'b0;
            sda_oe_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ADDR, REG, WDATA: begin
                    if (scl_rise) begin
                        shreg_nxt   = {shreg[6:0], sda};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        got8_nxt    = (bit_cnt == 3'd7);
                    end else if (scl_fall && got8) begin
                        got8_nxt   = 1'b0;
                        sda_oe_nxt = 1'b1;
                        case (state)
                            ADDR: begin
                                if (shreg[7:1] == DEV_ADDR) begin
                                    rw_nxt    = shreg[0];
                                    rd_en_nxt = shreg[0];
                                    state_nxt = ADDR_ACK;
                                end else begin
                                    sda_oe_nxt = 1'b0;
                                    state_nxt  = IDLE;
                                end
                            end
                            REG: begin
                                reg_addr_nxt = shreg;
                                state_nxt    = REG_ACK;
                            end
                            default: begin
                                wr_data_nxt = shreg;
                                wr_en_nxt   = 1'b1;
                                state_nxt   = WDATA_ACK;
                            end
                        endcase
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw) begin
                            sda_oe_nxt = ~shreg[7];
                            shreg_nxt  = {shreg[6:0], 1'b0};
                            state_nxt  = RDATA;
                        end else begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = REG;
                        end
                    end
                end
                REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt = 1'b0;
                        state_nxt  = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        got8_nxt    = (bit_cnt == 3'd7);
                    end else if (scl_fall) begin
                        if (got8) begin
                            got8_nxt   = 1'b0;
                            sda_oe_nxt = 1'b0;
                            state_nxt  = RDATA_ACK;
                        end else begin
                            sda_oe_nxt = ~shreg[7];
                            shreg_nxt  = {shreg[6:0], 1'b0};
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        ack_bit_nxt = sda;
                    end else if (scl_fall) begin
                        reg_addr_nxt = reg_addr + 8'd1;
                        if (!ack_bit) begin
                            rd_en_nxt = 1'b1;
                            state_nxt = RDATA;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged open-drain master, register-file read model, write/read scoreboards.
module tb_i2c_reg_slave;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m, m_sda;
    logic       sda_oe, wr_en, rd_en, busy;
    logic [7:0] reg_addr, wr_data, rd_data;
    logic       sda_line;

    assign sda_line = m_sda & ~sda_oe;

    i2c_reg_slave #(.DEV_ADDR(7'h42), .FILT(2)) dut (
        .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
        .reg_addr(reg_addr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file read port: mem[a] = a ^ 8'h5A, registered one clk after rd_en.
    always @(posedge clk) if (rd_en) rd_data <= reg_addr ^ 8'h5A;

    typedef struct {
        logic [7:0]  dev;
        logic [7:0]  rg;
        int          len;
        logic [23:0] dat;
        logic        ack;
        logic [7:0]  end_addr;
    } wvec_t;

    int n_cmp = 0, n_bad = 0;
    int wr_cnt = 0, rd_cnt = 0, oe_cnt = 0;
    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (sda_oe) oe_cnt++;
            if (wr_en) begin
                wr_cnt++;
                if (wr_q.size() == 0) check("wr_unexpected", 32'({reg_addr, wr_data}), 32'hFFFF_FFFF);
                else check("wr_addr_data", 32'({reg_addr, wr_data}), 32'(wr_q.pop_front()));
            end
            if (rd_en) begin
                rd_cnt++;
                if (rd_q.size() == 0) check("rd_unexpected", 32'(reg_addr), 32'hFFFF_FFFF);
                else check("rd_addr", 32'(reg_addr), 32'(rd_q.pop_front()));
            end
        end
    endtask

    task automatic bit_x(input logic b, output logic r);
        m_sda = b;     wait_clk(Q);
        scl_m = 1'b1;  wait_clk(Q);
        r = sda_line;  wait_clk(Q);
        scl_m = 1'b0;  wait_clk(Q);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;  wait_clk(Q);
        scl_m = 1'b1;  wait_clk(Q);
        m_sda = 1'b0;  wait_clk(Q);
        scl_m = 1'b0;  wait_clk(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;  wait_clk(Q);
        scl_m = 1'b1;  wait_clk(Q);
        m_sda = 1'b1;  wait_clk(2 * Q);
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(b[i], r);
        bit_x(1'b1, ack);
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] d);
        logic r;
        d = 8'd0;
        for (int i = 0; i < 8; i++) begin
            bit_x(1'b1, r);
            d = {d[6:0], r};
        end
        bit_x(nack, r);
    endtask

    task automatic do_write(input wvec_t v);
        logic a;
        logic [7:0] ad, b;
        int wr0, oe0;
        wr0 = wr_cnt;
        oe0 = oe_cnt;
        i2c_start();
        check("busy_after_start", 32'(busy), 32'(1));
        wbyte(v.dev, a);
        check("dev_ack", 32'(a), 32'(!v.ack));
        wbyte(v.rg, a);
        check("reg_ack", 32'(a), 32'(!v.ack));
        ad = v.rg;
        for (int k = 0; k < v.len; k++) begin
            b = v.dat[23 - 8 * k -: 8];
            if (v.ack) begin
                wr_q.push_back({ad, b});
                ad = ad + 8'd1;
            end
            wbyte(b, a);
            check("data_ack", 32'(a), 32'(!v.ack));
        end
        i2c_stop();
        check("busy_after_stop", 32'(busy), 32'(0));
        check("reg_addr_end", 32'(reg_addr), 32'(v.end_addr));
        check("wr_count", 32'(wr_cnt - wr0), v.ack ? 32'(v.len) : 32'(0));
        if (!v.ack) check("no_sda_drive", 32'(oe_cnt - oe0), 32'(0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wvec_t tbl[4];
        logic [7:0] rexp[4];
        logic a, r;
        logic [7:0] d;
        int rd0, wr0;

        tbl[0] = '{dev: 8'h84, rg: 8'h10, len: 3, dat: 24'hA1B2C3, ack: 1'b1, end_addr: 8'h13};
        tbl[1] = '{dev: 8'h84, rg: 8'hFE, len: 3, dat: 24'h112233, ack: 1'b1, end_addr: 8'h01};
        tbl[2] = '{dev: 8'h86, rg: 8'h55, len: 1, dat: 24'h770000, ack: 1'b0, end_addr: 8'h01};
        tbl[3] = '{dev: 8'h00, rg: 8'h66, len: 1, dat: 24'h880000, ack: 1'b0, end_addr: 8'h01};
        rexp   = '{8'h7A, 8'h7B, 8'h78, 8'h79};

        reset = 1'b1; scl_m = 1'b1; m_sda = 1'b1;
        wait_clk(5);
        check("rst_sda_oe", 32'(sda_oe), 32'(0));
        check("rst_wr_en", 32'(wr_en), 32'(0));
        check("rst_rd_en", 32'(rd_en), 32'(0));
        check("rst_wr_data", 32'(wr_data), 32'(0));
        check("rst_reg_addr", 32'(reg_addr), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        reset = 1'b0;
        wait_clk(10);
        fork monitor(); join_none

        for (int i = 0; i < 4; i++) do_write(tbl[i]);

        // Pointer write, STOP, then a 4-byte burst read ending in NACK.
        do_write('{dev: 8'h84, rg: 8'h20, len: 0, dat: 24'h0, ack: 1'b1, end_addr: 8'h20});
        rd0 = rd_cnt;
        for (int k = 0; k < 4; k++) rd_q.push_back(8'h20 + 8'(k));
        i2c_start();
        wbyte(8'h85, a);
        check("rd_dev_ack", 32'(a), 32'(0));
        for (int k = 0; k < 4; k++) begin
            rbyte(k == 3, d);
            check("rd_data", 32'(d), 32'(rexp[k]));
        end
        i2c_stop();
        check("rd_count", 32'(rd_cnt - rd0), 32'(4));
        check("rd_end_addr", 32'(reg_addr), 32'(8'h24));

        // Repeated START after the pointer phase keeps the pointer.
        i2c_start();
        wbyte(8'h84, a);
        check("rs_dev_ack", 32'(a), 32'(0));
        wbyte(8'h05, a);
        check("rs_reg_ack", 32'(a), 32'(0));
        rd_q.push_back(8'h05);
        i2c_start();
        check("rs_busy", 32'(busy), 32'(1));
        wbyte(8'h85, a);
        check("rs_rd_ack", 32'(a), 32'(0));
        rbyte(1'b1, d);
        check("rs_rd_data", 32'(d), 32'(8'h5F));
        wait_clk(4);
        check("rs_sda_released", 32'(sda_oe), 32'(0));
        check("rs_reg_addr", 32'(reg_addr), 32'(8'h06));
        i2c_stop();

        // Reset while the target drives a 0 in the 4th bit of a read byte (0x50 ^ 0x5A = 0x0A).
        do_write('{dev: 8'h84, rg: 8'h50, len: 0, dat: 24'h0, ack: 1'b1, end_addr: 8'h50});
        rd_q.push_back(8'h50);
        i2c_start();
        wbyte(8'h85, a);
        check("rst_rd_ack", 32'(a), 32'(0));
        for (int k = 0; k < 3; k++) bit_x(1'b1, r);
        m_sda = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        check("bit4_driven", 32'(sda_oe), 32'(1));
        reset = 1'b1;
        #1;
        check("mid_rst_sda_oe", 32'(sda_oe), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_reg_addr", 32'(reg_addr), 32'(0));
        check("mid_rst_fsm_idle", 32'(dut.state), 32'(0));
        wait_clk(3);
        reset = 1'b0;
        wait_clk(20);
        do_write('{dev: 8'h84, rg: 8'h07, len: 1, dat: 24'h990000, ack: 1'b1, end_addr: 8'h08});

        // One-clk SCL glitch in the middle of a data byte must not count as a bit.
        wr0 = wr_cnt;
        i2c_start();
        wbyte(8'h84, a);
        check("gl_dev_ack", 32'(a), 32'(0));
        wbyte(8'h30, a);
        check("gl_reg_ack", 32'(a), 32'(0));
        wr_q.push_back({8'h30, 8'h3C});
        d = 8'h3C;
        for (int i = 7; i >= 4; i--) bit_x(d[i], r);
        scl_m = 1'b1; wait_clk(1);
        scl_m = 1'b0; wait_clk(2);
        for (int i = 3; i >= 0; i--) bit_x(d[i], r);
        bit_x(1'b1, a);
        check("gl_data_ack", 32'(a), 32'(0));
        i2c_stop();
        check("gl_wr_count", 32'(wr_cnt - wr0), 32'(1));
        check("gl_reg_addr", 32'(reg_addr), 32'(8'h31));

        wait_clk(10);
        check("wr_q_drained", 32'(wr_q.size()), 32'(0));
        check("rd_q_drained", 32'(rd_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
